// File: rtl/led_pulse_ctrl_pkg.sv
// Shared encodings for the LED walking-pulse controller: press FSM states,
// pulse direction, reset pattern and the single-position rotate helper.
package led_pulse_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } press_state_e;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_e;

   localparam logic [7:0] LED_RESET = 8'h01;

   // Rotate keeps exactly one bit lit; the end positions wrap around.
   function automatic logic [7:0] step_led(input logic [7:0] led_cur, input dir_e dir);
      logic [7:0] led_nxt;
      if (dir == LEFT) begin
         led_nxt = {led_cur[6:0], led_cur[7]};
      end else begin
         led_nxt = {led_cur[0], led_cur[7:1]};
      end
      return led_nxt;
   endfunction

endpackage

// File: rtl/led_pulse_ctrl_tick_gen.sv
// Modulo-N cycle counter producing a one-cycle tick on its last count.
// Held at zero when disabled; a clear wins over the tick in the same cycle.
module tick_gen #(
   parameter int unsigned N = 4
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || !en_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pulse_ctrl.sv
// Classifies debounced button presses as short or long and drives a walking
// one-hot pulse on 8 LEDs, stepped manually or by a timed divider.
module led_pulse_ctrl
   import led_pulse_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   parameter int unsigned STEP_DIV    = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       db,
   output logic [7:0] led,
   output logic       auto_mode,
   output logic       short_evt,
   output logic       long_evt
);

   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   press_state_e  state_q;
   logic [HW-1:0] hold_q;
   logic          db_q;
   dir_e          dir_q;
   dir_e          dir_d;
   logic [7:0]    led_q;
   logic [7:0]    led_d;
   logic          auto_q;
   logic          short_q;
   logic          long_q;

   logic rise;
   logic short_hit;
   logic long_hit;
   logic step_tick;

   assign rise      = db & ~db_q;
   assign short_hit = (state_q == PRESSED) && !db;
   assign long_hit  = (state_q == PRESSED) && db && (hold_q == HOLD_LAST);

   // A long-press toggle clears the divider and swallows a coincident step.
   tick_gen #(
      .N (STEP_DIV)
   ) u_step_div (
      .clk    (clk),
      .rst_ni (reset),
      .clr_i  (long_hit),
      .en_i   (auto_q),
      .tick_o (step_tick)
   );

   // Reversal is resolved before stepping so a coincident auto step moves the new way.
   always_comb begin
      dir_d = dir_q;
      led_d = led_q;
      if (short_hit && auto_q) begin
         dir_d = (dir_q == LEFT) ? RIGHT : LEFT;
      end
      if ((short_hit && !auto_q) || step_tick) begin
         led_d = step_led(led_q, dir_d);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         db_q    <= 1'b0;
         dir_q   <= LEFT;
         led_q   <= LED_RESET;
         auto_q  <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         db_q    <= db;
         dir_q   <= dir_d;
         led_q   <= led_d;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_q <= PRESSED;
                  hold_q  <= '0;
               end
            end
            PRESSED: begin
               if (!db) begin
                  state_q <= IDLE;
                  short_q <= 1'b1;
               end else if (hold_q == HOLD_LAST) begin
                  state_q <= LONG;
                  auto_q  <= ~auto_q;
                  long_q  <= 1'b1;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            LONG: begin
               if (!db) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign led       = led_q;
   assign auto_mode = auto_q;
   assign short_evt = short_q;
   assign long_evt  = long_q;

endmodule
